// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int unsigned ADDR_W             = 22;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned CNT_W              = 4;
    localparam int unsigned STROBE_CYCLES_DEF  = 10;
    localparam int unsigned RECOVER_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    typedef logic port_t;
    localparam port_t PORT_VID = 1'b0;
    localparam port_t PORT_CPU = 1'b1;

    // Everything latched at grant and held for the whole slot.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        port_t             port;
    } slot_t;

    // Round-robin pick: on conflict the port that did not win last time goes.
    function automatic port_t pick_port(input logic vid_req, input logic cpu_req,
                                        input port_t last_grant);
        port_t p;
        if (vid_req && cpu_req) begin
            p = (last_grant == PORT_CPU) ? PORT_VID : PORT_CPU;
        end else if (cpu_req) begin
            p = PORT_CPU;
        end else begin
            p = PORT_VID;
        end
        return p;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter.sv
// Shares the single-port SDRAM controller between video fetch and CPU,
// turning each req/ack handshake into one fixed-length strobe slot.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES  = STROBE_CYCLES_DEF,
    parameter int unsigned RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic              clk50mhz,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_wdata,
    output logic              sd_rd,
    output logic              sd_we_n,
    input  logic [DATA_W-1:0] sd_rdata
);

    localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_t             last_grant_q, last_grant_d;
    slot_t             slot_q, slot_d;
    port_t             grant_port;
    logic              sd_rd_d, sd_we_n_d;
    logic              vid_ack_d, cpu_ack_d;
    logic [DATA_W-1:0] vid_rdata_d, cpu_rdata_d;

    // Address and write data come straight from the slot register.
    assign sd_addr  = slot_q.addr;
    assign sd_wdata = slot_q.wdata;

    // Next-state and next-output logic for the slot sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        slot_d       = slot_q;
        sd_rd_d      = 1'b0;
        sd_we_n_d    = 1'b1;
        vid_ack_d    = 1'b0;
        cpu_ack_d    = 1'b0;
        vid_rdata_d  = vid_rdata;
        cpu_rdata_d  = cpu_rdata;
        grant_port   = pick_port(vid_req, cpu_req, last_grant_q);

        case (state_q)
            ST_IDLE: begin
                if (vid_req || cpu_req) begin
                    slot_d.port = grant_port;
                    if (grant_port == PORT_CPU) begin
                        slot_d.addr  = cpu_addr;
                        slot_d.wdata = cpu_wdata;
                        slot_d.we    = cpu_we;
                    end else begin
                        // Video is read-only.
                        slot_d.addr  = vid_addr;
                        slot_d.wdata = '0;
                        slot_d.we    = 1'b0;
                    end
                    sd_rd_d   = ~slot_d.we;
                    sd_we_n_d = ~slot_d.we;
                    cnt_d     = STROBE_LOAD;
                    state_d   = ST_STROBE;
                end
            end

            ST_STROBE: begin
                if (cnt_q == '0) begin
                    // Slot ends: strobes drop (defaults), data captured, ack pulses.
                    if (slot_q.port == PORT_VID) begin
                        vid_ack_d   = 1'b1;
                        vid_rdata_d = sd_rdata;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!slot_q.we) begin
                            cpu_rdata_d = sd_rdata;
                        end
                    end
                    last_grant_d = slot_q.port;
                    cnt_d        = RECOVER_LOAD;
                    state_d      = ST_RECOVER;
                end else begin
                    sd_rd_d   = ~slot_q.we;
                    sd_we_n_d = ~slot_q.we;
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end

            ST_RECOVER: begin
                // Strobes idle so the controller re-arms its edge detector.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, slot and registered outputs; reset aborts any slot in flight.
    always_ff @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_CPU;
            slot_q       <= '0;
            sd_rd        <= 1'b0;
            sd_we_n      <= 1'b1;
            vid_ack      <= 1'b0;
            cpu_ack      <= 1'b0;
            vid_rdata    <= '0;
            cpu_rdata    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            slot_q       <= slot_d;
            sd_rd        <= sd_rd_d;
            sd_we_n      <= sd_we_n_d;
            vid_ack      <= vid_ack_d;
            cpu_ack      <= cpu_ack_d;
            vid_rdata    <= vid_rdata_d;
            cpu_rdata    <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small edge-triggered SDRAM controller model.
module tb_sdram_port_arbiter;

    logic        clk50mhz = 1'b0;
    logic        reset_n;
    logic        vid_req;
    logic [21:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [21:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [21:0] sd_addr;
    logic [7:0]  sd_wdata;
    logic        sd_rd;
    logic        sd_we_n;
    logic [7:0]  sd_rdata;

    int total = 0;
    int bad   = 0;
    int both_ack = 0;

    always #10 clk50mhz = ~clk50mhz;

    sdram_port_arbiter dut (
        .clk50mhz (clk50mhz),
        .reset_n  (reset_n),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_rdata(vid_rdata),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .sd_addr  (sd_addr),
        .sd_wdata (sd_wdata),
        .sd_rd    (sd_rd),
        .sd_we_n  (sd_we_n),
        .sd_rdata (sd_rdata)
    );

    // ---------------- controller model ----------------
    logic         force_refresh = 1'b0;
    logic         exrd;
    logic         exwe_n;
    int           rem;
    logic         op_we;
    logic [21:0]  op_addr;
    logic [7:0]   op_wdata;
    logic [7:0]   mem [256];
    logic [255:0] written = '0;
    int           model_reads  = 0;
    int           model_writes = 0;

    function automatic logic [7:0] init_val(input logic [21:0] a);
        case (a)
            22'h000123: return 8'hA5;
            22'h000031: return 8'h11;
            22'h000042: return 8'h22;
            22'h0000AB: return 8'h3C;
            22'h0000AC: return 8'h3D;
            22'h000020: return 8'h77;
            22'h000010: return 8'h99;
            default:    return 8'h00;
        endcase
    endfunction

    // Edge detect in idle, optional 3-cycle refresh stall, then 6 cycles of access.
    always @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            rem      <= 0;
            exrd     <= 1'b0;
            exwe_n   <= 1'b1;
            sd_rdata <= 8'h00;
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
        end else if (rem == 0) begin
            exrd   <= sd_rd;
            exwe_n <= sd_we_n;
            if (sd_rd && !exrd) begin
                rem     <= force_refresh ? 8 : 5;
                op_we   <= 1'b0;
                op_addr <= sd_addr;
            end else if (!sd_we_n && exwe_n) begin
                rem      <= force_refresh ? 8 : 5;
                op_we    <= 1'b1;
                op_addr  <= sd_addr;
                op_wdata <= sd_wdata;
            end
        end else begin
            rem <= rem - 1;
            if (rem == 1) begin
                if (op_we) begin
                    mem[op_addr[7:0]]     <= op_wdata;
                    written[op_addr[7:0]] <= 1'b1;
                    model_writes          <= model_writes + 1;
                end else begin
                    sd_rdata    <= written[op_addr[7:0]] ? mem[op_addr[7:0]] : init_val(op_addr);
                    model_reads <= model_reads + 1;
                end
            end
        end
    end

    // Counts any cycle where both acks are high.
    always @(negedge clk50mhz) begin
        if (vid_ack && cpu_ack) both_ack <= both_ack + 1;
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        vid_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk50mhz);
        total++; if (sd_rd !== 1'b0) begin bad++; $display("FAIL reset_sd_rd got=%b want=0", sd_rd); end
        total++; if (sd_we_n !== 1'b1) begin bad++; $display("FAIL reset_sd_we_n got=%b want=1", sd_we_n); end
        total++; if ({vid_ack, cpu_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b want=00", {vid_ack, cpu_ack}); end
        total++; if ({vid_rdata, cpu_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", {vid_rdata, cpu_rdata}); end
        total++; if ({sd_addr, sd_wdata} !== 30'h0) begin bad++; $display("FAIL reset_sd_bus got=%h want=0", {sd_addr, sd_wdata}); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk50mhz);
    endtask

    task automatic test_video_read();
        int strobe_n = 0, we_low = 0, ack_k = -1, acks = 0;
        logic [7:0]  rd = 8'h00;
        logic [21:0] a_at = '0;
        vid_addr = 22'h000123; vid_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk50mhz);
            if (sd_rd) strobe_n++;
            if (!sd_we_n) we_low++;
            if (k == 1) a_at = sd_addr;
            if (vid_ack) begin
                acks++;
                if (ack_k < 0) ack_k = k;
                rd = vid_rdata;
                vid_req = 1'b0;
            end
        end
        total++; if (strobe_n !== 10) begin bad++; $display("FAIL vid_strobe_len got=%0d want=10", strobe_n); end
        total++; if (we_low !== 0) begin bad++; $display("FAIL vid_no_write got=%0d want=0", we_low); end
        total++; if (ack_k !== 11) begin bad++; $display("FAIL vid_ack_latency got=%0d want=11", ack_k); end
        total++; if (acks !== 1) begin bad++; $display("FAIL vid_ack_count got=%0d want=1", acks); end
        total++; if (rd !== 8'hA5) begin bad++; $display("FAIL vid_rdata got=%h want=a5", rd); end
        total++; if (a_at !== 22'h000123) begin bad++; $display("FAIL vid_sd_addr got=%h want=000123", a_at); end
    endtask

    task automatic test_cpu_write();
        int we_low = 0, rd_high = 0, unstable = 0, ack_k = -1;
        cpu_we = 1'b1; cpu_addr = 22'h3FFFFF; cpu_wdata = 8'h5A; cpu_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk50mhz);
            if (!sd_we_n) begin
                we_low++;
                if (sd_addr !== 22'h3FFFFF || sd_wdata !== 8'h5A) unstable++;
            end
            if (sd_rd) rd_high++;
            if (k == 2) begin
                cpu_addr = 22'h000000; cpu_wdata = 8'hFF; cpu_we = 1'b0;
            end
            if (cpu_ack) begin
                if (ack_k < 0) ack_k = k;
                cpu_req = 1'b0;
            end
        end
        total++; if (we_low !== 10) begin bad++; $display("FAIL cpu_wr_strobe_len got=%0d want=10", we_low); end
        total++; if (rd_high !== 0) begin bad++; $display("FAIL cpu_wr_no_rd got=%0d want=0", rd_high); end
        total++; if (unstable !== 0) begin bad++; $display("FAIL cpu_wr_bus_stable got=%0d want=0", unstable); end
        total++; if (ack_k !== 11) begin bad++; $display("FAIL cpu_wr_ack_latency got=%0d want=11", ack_k); end
        total++; if ({written[8'hFF], mem[8'hFF]} !== 9'h15A) begin bad++; $display("FAIL cpu_wr_mem got=%h want=15a", {written[8'hFF], mem[8'hFF]}); end
    endtask

    task automatic test_cpu_read_back();
        int ack_k = -1;
        logic [7:0] rd = 8'h00;
        cpu_we = 1'b0; cpu_addr = 22'h3FFFFF; cpu_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk50mhz);
            if (cpu_ack) begin
                if (ack_k < 0) ack_k = k;
                rd = cpu_rdata;
                cpu_req = 1'b0;
            end
        end
        total++; if (ack_k !== 11) begin bad++; $display("FAIL cpu_rd_ack_latency got=%0d want=11", ack_k); end
        total++; if (rd !== 8'h5A) begin bad++; $display("FAIL cpu_rd_data got=%h want=5a", rd); end
    endtask

    task automatic test_contention();
        int n = 0, reads0;
        int ack_cyc [8];
        logic ack_port [8];
        int exp_cyc [4] = '{11, 26, 41, 56};
        logic exp_port [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset_n = 1'b0;
        @(negedge clk50mhz);
        vid_addr = 22'h000031; cpu_addr = 22'h000042; cpu_we = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1;
        reads0 = model_reads;
        @(negedge clk50mhz);
        reset_n = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk50mhz);
            if (vid_ack && n < 8) begin ack_cyc[n] = k; ack_port[n] = 1'b0; n++; end
            if (cpu_ack && n < 8) begin ack_cyc[n] = k; ack_port[n] = 1'b1; n++; end
            if (k == 60) begin vid_req = 1'b0; cpu_req = 1'b0; end
        end
        repeat (2) @(negedge clk50mhz);
        total++; if (n !== 4) begin bad++; $display("FAIL cont_ack_count got=%0d want=4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            total++;
            if (ack_cyc[i] !== exp_cyc[i] || ack_port[i] !== exp_port[i]) begin
                bad++;
                $display("FAIL cont_ack_%0d got cyc=%0d port=%b want cyc=%0d port=%b",
                         i, ack_cyc[i], ack_port[i], exp_cyc[i], exp_port[i]);
            end
        end
        total++; if (model_reads - reads0 !== 4) begin bad++; $display("FAIL cont_model_reads got=%0d want=4", model_reads - reads0); end
        total++; if ({vid_rdata, cpu_rdata} !== 16'h1122) begin bad++; $display("FAIL cont_rdata got=%h want=1122", {vid_rdata, cpu_rdata}); end
    endtask

    task automatic test_refresh();
        int reads0, acks = 0, fall1 = -1, rise2 = -1;
        logic prev = 1'b0;
        logic [7:0] d1 = 8'h00, d2 = 8'h00;
        force_refresh = 1'b1;
        reads0 = model_reads;
        vid_addr = 22'h0000AB; vid_req = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk50mhz);
            if (!sd_rd && prev && fall1 < 0) fall1 = k;
            if (sd_rd && !prev && fall1 >= 0 && rise2 < 0) rise2 = k;
            prev = sd_rd;
            if (vid_ack) begin
                acks++;
                if (acks == 1) begin d1 = vid_rdata; vid_addr = 22'h0000AC; end
                else begin d2 = vid_rdata; vid_req = 1'b0; end
            end
        end
        force_refresh = 1'b0;
        total++; if (d1 !== 8'h3C) begin bad++; $display("FAIL refresh_rdata1 got=%h want=3c", d1); end
        total++; if (d2 !== 8'h3D) begin bad++; $display("FAIL refresh_rdata2 got=%h want=3d", d2); end
        total++; if (rise2 - fall1 !== 5) begin bad++; $display("FAIL refresh_idle_gap got=%0d want=5", rise2 - fall1); end
        total++; if (model_reads - reads0 !== 2) begin bad++; $display("FAIL refresh_model_reads got=%0d want=2", model_reads - reads0); end
        total++; if (acks !== 2) begin bad++; $display("FAIL refresh_ack_count got=%0d want=2", acks); end
    endtask

    task automatic test_back_to_back();
        int acks = 0, rise1 = -1, rise2 = -1;
        logic prev = 1'b0;
        logic [7:0] d1 = 8'h00, d2 = 8'h00;
        cpu_we = 1'b0; cpu_addr = 22'h000020; cpu_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk50mhz);
            if (sd_rd && !prev) begin
                if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
            end
            prev = sd_rd;
            if (cpu_ack) begin
                acks++;
                if (acks == 1) begin d1 = cpu_rdata; cpu_addr = 22'h000010; end
                else begin d2 = cpu_rdata; cpu_req = 1'b0; end
            end
        end
        total++; if (acks !== 2) begin bad++; $display("FAIL b2b_ack_count got=%0d want=2", acks); end
        total++; if (rise2 - rise1 !== 15) begin bad++; $display("FAIL b2b_slot_period got=%0d want=15", rise2 - rise1); end
        total++; if ({d1, d2} !== 16'h7799) begin bad++; $display("FAIL b2b_rdata got=%h want=7799", {d1, d2}); end
    endtask

    task automatic test_reset_mid_slot();
        int acks_rst = 0, acks = 0, ack_k = -1;
        cpu_we = 1'b1; cpu_addr = 22'h000055; cpu_wdata = 8'h66; cpu_req = 1'b1;
        repeat (5) @(negedge clk50mhz);
        total++; if (sd_we_n !== 1'b0) begin bad++; $display("FAIL midrst_pre_we_n got=%b want=0", sd_we_n); end
        #2 reset_n = 1'b0;
        #1;
        total++; if ({sd_rd, sd_we_n} !== 2'b01) begin bad++; $display("FAIL midrst_async_strobes got=%b want=01", {sd_rd, sd_we_n}); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk50mhz);
            if (vid_ack || cpu_ack) acks_rst++;
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk50mhz);
            if (vid_ack || cpu_ack) begin
                acks++;
                if (ack_k < 0) ack_k = k;
                cpu_req = 1'b0;
            end
        end
        total++; if (acks_rst !== 0) begin bad++; $display("FAIL midrst_no_ack got=%0d want=0", acks_rst); end
        total++; if (ack_k !== 11) begin bad++; $display("FAIL midrst_resume_latency got=%0d want=11", ack_k); end
        total++; if (acks !== 1) begin bad++; $display("FAIL midrst_ack_count got=%0d want=1", acks); end
        total++; if ({written[8'h55], mem[8'h55]} !== 9'h166) begin bad++; $display("FAIL midrst_mem got=%h want=166", {written[8'h55], mem[8'h55]}); end
    endtask

    initial begin
        test_reset();
        test_video_read();
        test_cpu_write();
        test_cpu_read_back();
        test_contention();
        test_refresh();
        test_back_to_back();
        test_reset_mid_slot();
        total++;
        if (both_ack !== 0) begin bad++; $display("FAIL dual_ack got=%0d want=0", both_ack); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
